// File: rtl/p23_mem_bus_arbiter.sv
// Two-master arbiter for the native mem_valid/mem_ready bus: CPU (port 0) and DMA (port 1)
// share one downstream port through a registered grant FSM with a no-answer watchdog.
module p23_mem_bus_arbiter #(
  parameter int unsigned CPU_PRIORITY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_fault,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_fault,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_fault,
  output logic [1:0]  grant
);

  localparam logic                 TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        sel;
  logic        own_valid;
  logic        done;
  logic        done_fault;
  logic [31:0] done_rdata;

  // State, last owner and watchdog registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant decision, payload mux, completion and watchdog
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    sel        = (state_q == OWN1);
    own_valid  = 1'b0;
    done       = 1'b0;
    done_fault = 1'b0;
    done_rdata = '0;
    s_valid    = 1'b0;
    s_wstrb    = '0;
    s_addr     = '0;
    s_wdata    = '0;
    grant      = 2'b00;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_valid && m1_valid) begin
          // last_q==1 means port 1 owned last, so port 0 takes the tie
          if ((CPU_PRIORITY != 0) || last_q) state_d = OWN0;
          else                                state_d = OWN1;
        end else if (m0_valid) begin
          state_d = OWN0;
        end else if (m1_valid) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        grant     = sel ? 2'b10 : 2'b01;
        own_valid = sel ? m1_valid : m0_valid;
        s_wstrb   = sel ? m1_wstrb : m0_wstrb;
        s_addr    = sel ? m1_addr  : m0_addr;
        s_wdata   = sel ? m1_wdata : m0_wdata;
        if (!own_valid) begin
          state_d = IDLE;
        end else if (s_ready) begin
          s_valid    = 1'b1;
          done       = 1'b1;
          done_fault = s_fault;
          done_rdata = s_rdata;
          state_d    = IDLE;
          last_d     = sel;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // Downstream never answered: fault the owner and withdraw the request
          done       = 1'b1;
          done_fault = 1'b1;
          state_d    = IDLE;
          last_d     = sel;
        end else begin
          s_valid = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    m0_ready = done && !sel;
    m0_fault = done && !sel && done_fault;
    m0_rdata = (done && !sel) ? done_rdata : '0;
    m1_ready = done && sel;
    m1_fault = done && sel && done_fault;
    m1_rdata = (done && sel) ? done_rdata : '0;
  end

endmodule

// File: tb/tb_p23_mem_bus_arbiter.sv
// Directed bench: round-robin instance (TIMEOUT 8) plus a CPU-priority instance for tie order.
module tb_p23_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid, p_m0_valid, p_m1_valid;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        s_ready, s_fault;
  logic [31:0] s_rdata;

  logic        m0_ready, m0_fault, m1_ready, m1_fault, s_valid;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  logic        p_m0_ready, p_m0_fault, p_m1_ready, p_m1_fault, p_s_valid;
  logic [31:0] p_m0_rdata, p_m1_rdata, p_s_addr, p_s_wdata;
  logic [3:0]  p_s_wstrb;
  logic [1:0]  p_grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  p23_mem_bus_arbiter #(.CPU_PRIORITY(0), .TIMEOUT_CYCLES(8), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_fault(s_fault), .grant(grant)
  );

  p23_mem_bus_arbiter #(.CPU_PRIORITY(1), .TIMEOUT_CYCLES(8), .CNT_WIDTH(8)) u_prio (
    .clk(clk), .resetn(resetn),
    .m0_valid(p_m0_valid), .m0_ready(p_m0_ready), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(p_m0_rdata), .m0_fault(p_m0_fault),
    .m1_valid(p_m1_valid), .m1_ready(p_m1_ready), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(p_m1_rdata), .m1_fault(p_m1_fault),
    .s_valid(p_s_valid), .s_ready(s_ready), .s_wstrb(p_s_wstrb), .s_addr(p_s_addr),
    .s_wdata(p_s_wdata), .s_rdata(s_rdata), .s_fault(s_fault), .grant(p_grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    resetn = 1'b0;
    m0_valid = 0; m1_valid = 0; p_m0_valid = 0; p_m1_valid = 0;
    m0_wstrb = '0; m1_wstrb = '0; m0_addr = '0; m1_addr = '0;
    m0_wdata = '0; m1_wdata = '0;
    s_ready = 0; s_fault = 0; s_rdata = '0;
    do_reset();

    // Reset state
    check("rst_grant",   32'(grant), 32'h0);
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_s_addr",  s_addr, 32'h0);
    check("rst_m0_ready", 32'(m0_ready), 32'h0);

    // Basic m0 read
    m0_valid = 1; m0_addr = 32'h1000; m0_wstrb = 4'b0000;
    settle();
    check("rd_c0_ready", 32'(m0_ready), 32'h0);
    tick();
    check("rd_grant",   32'(grant), 32'h1);
    check("rd_s_valid", 32'(s_valid), 32'h1);
    check("rd_s_addr",  s_addr, 32'h1000);
    check("rd_c1_ready", 32'(m0_ready), 32'h0);
    s_ready = 1; s_rdata = 32'hDEADBEEF;
    settle();
    check("rd_ready", 32'(m0_ready), 32'h1);
    check("rd_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_fault", 32'(m0_fault), 32'h0);
    check("rd_m1_ready", 32'(m1_ready), 32'h0);
    tick();
    m0_valid = 0; s_ready = 0;
    settle();
    check("rd_idle_grant", 32'(grant), 32'h0);
    check("rd_idle_ready", 32'(m0_ready), 32'h0);
    check("rd_idle_rdata", m0_rdata, 32'h0);

    // Tie arbitration: round-robin alternates, priority instance always picks port 0
    do_reset();
    m0_valid = 1; m1_valid = 1; p_m0_valid = 1; p_m1_valid = 1;
    s_rdata = 32'h1234_0000;
    for (int r = 0; r < 4; r++) begin
      tick();
      check("tie_grant", 32'(grant), (r % 2 == 0) ? 32'h1 : 32'h2);
      check("tie_p_grant", 32'(p_grant), 32'h1);
      s_ready = 1;
      settle();
      check("tie_ready_m0", 32'(m0_ready), (r % 2 == 0) ? 32'h1 : 32'h0);
      check("tie_ready_m1", 32'(m1_ready), (r % 2 == 0) ? 32'h0 : 32'h1);
      check("tie_p_ready_m0", 32'(p_m0_ready), 32'h1);
      tick();
      s_ready = 0;
      settle();
      check("tie_gap_grant", 32'(grant), 32'h0);
      check("tie_gap_p_grant", 32'(p_grant), 32'h0);
    end
    m0_valid = 0; m1_valid = 0; p_m0_valid = 0; p_m1_valid = 0;
    tick();

    // m1 write with no downstream answer: watchdog fault on 8th granted cycle
    m1_valid = 1; m1_wstrb = 4'b0011; m1_wdata = 32'h0000ABCD; m1_addr = 32'h2000;
    s_rdata = 32'hCAFEF00D;
    tick();
    check("to_grant",   32'(grant), 32'h2);
    check("to_s_wstrb", 32'(s_wstrb), 32'h3);
    check("to_s_wdata", s_wdata, 32'h0000ABCD);
    for (int c = 2; c <= 7; c++) begin
      tick();
      check("to_wait_ready", 32'(m1_ready), 32'h0);
      check("to_wait_s_valid", 32'(s_valid), 32'h1);
    end
    tick();
    check("to_ready",   32'(m1_ready), 32'h1);
    check("to_fault",   32'(m1_fault), 32'h1);
    check("to_rdata",   m1_rdata, 32'h0);
    check("to_s_valid", 32'(s_valid), 32'h0);
    tick();
    m1_valid = 0;
    settle();
    check("to_after_grant", 32'(grant), 32'h0);
    tick();

    // s_ready arriving in the watchdog expiry cycle completes normally
    m0_valid = 1; m0_addr = 32'h3000; m0_wstrb = 4'b0000; s_fault = 0;
    s_rdata = 32'h55AA_55AA;
    for (int c = 1; c <= 7; c++) tick();
    check("race_pre_ready", 32'(m0_ready), 32'h0);
    tick();
    s_ready = 1;
    settle();
    check("race_ready", 32'(m0_ready), 32'h1);
    check("race_fault", 32'(m0_fault), 32'h0);
    check("race_rdata", m0_rdata, 32'h55AA_55AA);
    check("race_s_valid", 32'(s_valid), 32'h1);
    tick();
    m0_valid = 0; s_ready = 0;
    tick();

    // Downstream decode fault propagates on port 1
    m1_valid = 1; m1_wstrb = 4'b0000; m1_addr = 32'hF000_0000;
    tick();
    s_ready = 1; s_fault = 1;
    settle();
    check("dfault_ready", 32'(m1_ready), 32'h1);
    check("dfault_fault", 32'(m1_fault), 32'h1);
    check("dfault_m0_fault", 32'(m0_fault), 32'h0);
    tick();
    m1_valid = 0; s_ready = 0; s_fault = 0;
    tick();

    // m0 withdraws before s_ready: abort without ready
    m0_valid = 1; m0_addr = 32'h4000;
    tick();
    check("ab_grant", 32'(grant), 32'h1);
    m0_valid = 0;
    settle();
    check("ab_s_valid", 32'(s_valid), 32'h0);
    check("ab_ready",   32'(m0_ready), 32'h0);
    tick();
    check("ab_idle", 32'(grant), 32'h0);
    tick();

    // Reset during OWN1, then port 0 wins the first tie
    m1_valid = 1; m1_addr = 32'h5000;
    tick();
    check("rm_grant", 32'(grant), 32'h2);
    m0_valid = 1;
    #2;
    resetn = 0;
    #1;
    check("rm_grant_rst", 32'(grant), 32'h0);
    check("rm_s_valid",   32'(s_valid), 32'h0);
    check("rm_s_addr",    s_addr, 32'h0);
    check("rm_m1_ready",  32'(m1_ready), 32'h0);
    tick();
    resetn = 1;
    tick();
    check("rm_tie_grant", 32'(grant), 32'h1);
    m0_valid = 0; m1_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
